pe_ctx_seq: RTL and testbench
=============================

Name: pe_ctx_seq

Overview:
- Per-PE context sequencer directly upstream of the PE register-file stage; owns the context (configuration) memory of one CGRA PE.
- Stores DEPTH context words, steps through contexts 0..last_ctx for iter_count iterations, and drives every register-file control field from a flop on each posedge CLK.
- The register file samples on negedge, so fields are stable for half a cycle before use.
- Outside a run it drives a safe "hold" pattern so the register file does not modify any entry.

Parameters:
- DEPTH, 16, number of context words.
- AW, 4, context address width (clog2 DEPTH).
- WORD_W, 64, context word width (fixed layout below; bits 63:62 reserved).

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  asynchronous active-high reset.
- cfg_we  in  1  context write strobe.
- cfg_addr  in  AW  context write address.
- cfg_data  in  WORD_W  context write data.
- start  in  1  begin run (sampled in IDLE only).
- abort  in  1  terminate run.
- last_ctx  in  AW  index of last context per iteration (sampled at start).
- iter_count  in  16  iterations to run (sampled at start; 0 treated as 1).
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on normal completion.
- cfg_err  out  1  one-cycle pulse when cfg_we arrives while busy.
- ctx_ptr  out  AW  index of the context currently driven.
- control_in, control_out  out  9  register-file input/output edge selects.
- control_reg_1, control_reg_2, control_put_in, control_put_out, control_send  out  6  register-file indices.
- control_pe2fu_1, control_pe2fu_2  out  4  FU bypass selects.
- write_back  out  1  FU result write enable.
- fu_op  out  5  FU opcode.
- rf_ld  out  1  register-file ld.
- rf_ld_write  out  1  register-file ld_write.

Behaviour:
- Context word layout (LSB first): control_in[8:0], control_out[17:9], control_reg_1[23:18], control_reg_2[29:24], control_put_in[35:30], control_put_out[41:36], control_send[47:42], control_pe2fu_1[51:48], control_pe2fu_2[55:52], write_back[56], fu_op[61:57], reserved[63:62] (ignored).
- Reset values:
  - All control fields, fu_op, write_back, ctx_ptr, busy, done and cfg_err are 0.
  - rf_ld = 1 and rf_ld_write = 0 (the hold pattern).
  - State = IDLE.
  - Context memory is not reset and its contents survive RST.
- States are IDLE, RUN and DONE.
  - IDLE:
    - cfg_we writes mem[cfg_addr] at the posedge.
    - On start: latch last_ctx and iter_count, load mem[0] fields onto the outputs, set ctx_ptr = 0, iteration counter = 1, rf_ld = 0, busy = 1, and go to RUN. Fields are therefore valid the cycle after start is sampled.
    - If cfg_we and start occur together, the write completes, but the context loaded at that edge is the pre-write contents.
  - RUN, at each posedge:
    - If ctx_ptr < latched last_ctx: ctx_ptr + 1, load that word.
    - If ctx_ptr == last_ctx and the iteration counter < iter_count: ctx_ptr wraps to 0, the counter increments, and mem[0] is loaded.
    - Otherwise go to DONE.
  - DONE:
    - Outputs are at the hold pattern (fields 0, rf_ld = 1, rf_ld_write = 0), busy = 0, done = 1 for exactly one cycle, then IDLE.
- abort in RUN: the next posedge drives the hold pattern, busy = 0, and returns to IDLE with no done pulse. abort in IDLE or DONE is ignored.
- cfg_we in RUN or DONE: no write takes place and cfg_err pulses one cycle.
- start outside IDLE is ignored.
- last_ctx ≥ DEPTH is clamped to DEPTH-1 at latch.
- The iteration counter is 16 bits, so 65535 iterations is the maximum with no overflow.
- Throughput: one context per cycle. Total RUN cycles = (last_ctx+1) × max(iter_count, 1).
- RST mid-run: immediate hold pattern and IDLE; memory is kept.

Decomposition:
- Package pe_ctx_pkg holds:
  - the field LSB/width constants for the layout above;
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - the hold-pattern constant.
- Sub-module pe_ctx_mem: DEPTH × WORD_W, one synchronous write port, one asynchronous read port. The sequencer holds the FSM, counters, field slicing and output flops.

Test Plan:
- Reset then idle → all fields 0, rf_ld = 1, rf_ld_write = 0, busy = 0. The register file holds its contents across 10 cycles.
- Write ctx0..2 with distinct patterns (e.g. control_put_in = 1, 2, 3); start with last_ctx = 2, iter_count = 2 → ctx_ptr sequence 0,1,2,0,1,2 in cycles 1–6 after start, fields match each word, done pulses in cycle 7, busy falls in cycle 7.
- iter_count = 0, last_ctx = 0 → exactly one context cycle, then done.
- abort in the second RUN cycle → the next cycle is the hold pattern, busy = 0, done never asserts. A following start runs normally.
- cfg_we during RUN to addr 1 → cfg_err pulse, mem[1] unchanged (verified by a rerun). cfg_we to addr 0 together with start → the first run uses the old word and the second run uses the new word.
- Assert RST in mid-run at ctx_ptr = 1 → outputs return to reset values asynchronously. After release, a rerun without reloading reproduces the original context fields.

Source files
------------

// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the PE context sequencer.
// - Field positions and widths of the 64-bit context word (bits 63:62 reserved).
// - FSM state encoding.
// - Hold pattern driven to the register file outside a run.
// - Helper that slices a context word into its control fields.
package pe_ctx_pkg;

    localparam int unsigned CTRL_IN_LSB   = 0;
    localparam int unsigned CTRL_OUT_LSB  = 9;
    localparam int unsigned REG_1_LSB     = 18;
    localparam int unsigned REG_2_LSB     = 24;
    localparam int unsigned PUT_IN_LSB    = 30;
    localparam int unsigned PUT_OUT_LSB   = 36;
    localparam int unsigned SEND_LSB      = 42;
    localparam int unsigned PE2FU_1_LSB   = 48;
    localparam int unsigned PE2FU_2_LSB   = 52;
    localparam int unsigned WB_LSB        = 56;
    localparam int unsigned FU_OP_LSB     = 57;
    localparam int unsigned FIELDS_W      = 62;

    localparam int unsigned EDGE_W  = 9;
    localparam int unsigned IDX_W   = 6;
    localparam int unsigned BYP_W   = 4;
    localparam int unsigned FU_OP_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [FU_OP_W-1:0] fu_op;
        logic               write_back;
        logic [BYP_W-1:0]   pe2fu_2;
        logic [BYP_W-1:0]   pe2fu_1;
        logic [IDX_W-1:0]   send;
        logic [IDX_W-1:0]   put_out;
        logic [IDX_W-1:0]   put_in;
        logic [IDX_W-1:0]   reg_2;
        logic [IDX_W-1:0]   reg_1;
        logic [EDGE_W-1:0]  ctrl_out;
        logic [EDGE_W-1:0]  ctrl_in;
    } ctx_fields_t;

    // Register file leaves every entry untouched with all fields 0, ld=1, ld_write=0.
    localparam ctx_fields_t HOLD_FIELDS      = '0;
    localparam logic        HOLD_RF_LD       = 1'b1;
    localparam logic        HOLD_RF_LD_WRITE = 1'b0;

    function automatic ctx_fields_t unpack_ctx(input logic [FIELDS_W-1:0] w);
        ctx_fields_t f;
        f.ctrl_in    = w[CTRL_IN_LSB  +: EDGE_W];
        f.ctrl_out   = w[CTRL_OUT_LSB +: EDGE_W];
        f.reg_1      = w[REG_1_LSB    +: IDX_W];
        f.reg_2      = w[REG_2_LSB    +: IDX_W];
        f.put_in     = w[PUT_IN_LSB   +: IDX_W];
        f.put_out    = w[PUT_OUT_LSB  +: IDX_W];
        f.send       = w[SEND_LSB     +: IDX_W];
        f.pe2fu_1    = w[PE2FU_1_LSB  +: BYP_W];
        f.pe2fu_2    = w[PE2FU_2_LSB  +: BYP_W];
        f.write_back = w[WB_LSB];
        f.fu_op      = w[FU_OP_LSB    +: FU_OP_W];
        return f;
    endfunction

endpackage

// File: rtl/pe_ctx_seq_if.sv
// Bus between the context sequencer and its surroundings.
// - Configuration write port (cfg_we/cfg_addr/cfg_data).
// - Run control (start/abort/last_ctx/iter_count) and status (busy/done/cfg_err/ctx_ptr).
// - Register-file / FU control fields driven by the sequencer.
// slave = sequencer side, master = controller / register-file side.
interface pe_ctx_seq_if #(
    parameter int unsigned AW     = 4,
    parameter int unsigned WORD_W = 64
);
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [WORD_W-1:0] cfg_data;
    logic              start;
    logic              abort;
    logic [AW-1:0]     last_ctx;
    logic [15:0]       iter_count;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic [AW-1:0]     ctx_ptr;
    logic [8:0]        control_in;
    logic [8:0]        control_out;
    logic [5:0]        control_reg_1;
    logic [5:0]        control_reg_2;
    logic [5:0]        control_put_in;
    logic [5:0]        control_put_out;
    logic [5:0]        control_send;
    logic [3:0]        control_pe2fu_1;
    logic [3:0]        control_pe2fu_2;
    logic              write_back;
    logic [4:0]        fu_op;
    logic              rf_ld;
    logic              rf_ld_write;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, abort, last_ctx, iter_count,
        output busy, done, cfg_err, ctx_ptr, control_in, control_out,
               control_reg_1, control_reg_2, control_put_in, control_put_out,
               control_send, control_pe2fu_1, control_pe2fu_2, write_back,
               fu_op, rf_ld, rf_ld_write
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, abort, last_ctx, iter_count,
        input  busy, done, cfg_err, ctx_ptr, control_in, control_out,
               control_reg_1, control_reg_2, control_put_in, control_put_out,
               control_send, control_pe2fu_1, control_pe2fu_2, write_back,
               fu_op, rf_ld, rf_ld_write
    );
endinterface

// File: rtl/pe_ctx_mem.sv
// Context memory: DEPTH x WORD_W, one synchronous write port, one asynchronous
// read port. Not reset, so contents survive RST.
// - clk/we/waddr/wdata: write port.
// - raddr/rdata: combinational read (pre-write contents on a same-edge write).
module pe_ctx_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned WORD_W = 64
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/pe_ctx_seq.sv
// Per-PE context sequencer. Steps contexts 0..last_ctx for iter_count iterations
// and drives every register-file control field from a flop; outside a run it
// drives the hold pattern.
// - CLK/RST: clock, asynchronous active-high reset.
// - bus: pe_ctx_seq_if slave (config port, run control, status, control fields).
import pe_ctx_pkg::*;

module pe_ctx_seq #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned WORD_W = 64
) (
    input  logic            CLK,
    input  logic            RST,
    pe_ctx_seq_if.slave     bus
);
    state_e            state_q, state_d;
    logic [AW-1:0]     ptr_q, ptr_d;
    logic [AW-1:0]     last_q, last_d;
    logic [15:0]       iter_q, iter_d;
    logic [15:0]       target_q, target_d;
    ctx_fields_t       fields_q, fields_d;
    logic              rf_ld_q, rf_ld_d;
    logic              rf_ld_write_q, rf_ld_write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              cfg_err_q, cfg_err_d;

    logic [AW-1:0]     rd_addr;
    logic [WORD_W-1:0] rd_word;
    logic              mem_we;
    logic              unused_rsvd;

    assign mem_we      = bus.cfg_we && (state_q == ST_IDLE);
    assign unused_rsvd = ^rd_word[WORD_W-1:FIELDS_W];

    pe_ctx_mem #(.DEPTH(DEPTH), .AW(AW), .WORD_W(WORD_W)) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (bus.cfg_addr),
        .wdata (bus.cfg_data),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    // Every cycle defaults to the hold pattern; only a context load overrides it.
    always_comb begin
        state_d       = state_q;
        ptr_d         = '0;
        last_d        = last_q;
        iter_d        = iter_q;
        target_d      = target_q;
        fields_d      = HOLD_FIELDS;
        rf_ld_d       = HOLD_RF_LD;
        rf_ld_write_d = HOLD_RF_LD_WRITE;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        cfg_err_d     = bus.cfg_we && (state_q != ST_IDLE);
        rd_addr       = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    last_d   = ({1'b0, bus.last_ctx} >= (AW+1)'(DEPTH)) ? AW'(DEPTH-1) : bus.last_ctx;
                    target_d = (bus.iter_count == 16'd0) ? 16'd1 : bus.iter_count;
                    iter_d   = 16'd1;
                    fields_d = unpack_ctx(rd_word[FIELDS_W-1:0]);
                    rf_ld_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (ptr_q < last_q) begin
                    rd_addr  = ptr_q + 1'b1;
                    ptr_d    = rd_addr;
                    fields_d = unpack_ctx(rd_word[FIELDS_W-1:0]);
                    rf_ld_d  = 1'b0;
                    busy_d   = 1'b1;
                end else if (iter_q < target_q) begin
                    iter_d   = iter_q + 16'd1;
                    fields_d = unpack_ctx(rd_word[FIELDS_W-1:0]);
                    rf_ld_d  = 1'b0;
                    busy_d   = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            last_q        <= '0;
            iter_q        <= '0;
            target_q      <= '0;
            fields_q      <= HOLD_FIELDS;
            rf_ld_q       <= HOLD_RF_LD;
            rf_ld_write_q <= HOLD_RF_LD_WRITE;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            last_q        <= last_d;
            iter_q        <= iter_d;
            target_q      <= target_d;
            fields_q      <= fields_d;
            rf_ld_q       <= rf_ld_d;
            rf_ld_write_q <= rf_ld_write_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_err_q     <= cfg_err_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cfg_err         = cfg_err_q;
    assign bus.ctx_ptr         = ptr_q;
    assign bus.control_in      = fields_q.ctrl_in;
    assign bus.control_out     = fields_q.ctrl_out;
    assign bus.control_reg_1   = fields_q.reg_1;
    assign bus.control_reg_2   = fields_q.reg_2;
    assign bus.control_put_in  = fields_q.put_in;
    assign bus.control_put_out = fields_q.put_out;
    assign bus.control_send    = fields_q.send;
    assign bus.control_pe2fu_1 = fields_q.pe2fu_1;
    assign bus.control_pe2fu_2 = fields_q.pe2fu_2;
    assign bus.write_back      = fields_q.write_back;
    assign bus.fu_op           = fields_q.fu_op;
    assign bus.rf_ld           = rf_ld_q;
    assign bus.rf_ld_write     = rf_ld_write_q;
endmodule

// File: tb/tb_pe_ctx_seq.sv
module tb_pe_ctx_seq;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pe_ctx_seq_if #(.AW(4), .WORD_W(64)) bus();
    pe_ctx_seq #(.DEPTH(16), .AW(4), .WORD_W(64)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: a run is the list of context indices it will visit.
    logic [63:0] m_mem [16];
    int          m_seq [$];
    bit          m_run  = 0;
    bit          m_done = 0;
    bit          m_err  = 0;
    int          m_cur  = 0;
    logic [63:0] m_word = '0;
    bit          m_idle;
    int          m_last, m_n;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_run = 0; m_done = 0; m_err = 0; m_cur = 0; m_seq.delete();
        end else begin
            m_idle = !m_run && !m_done;
            m_err  = (bus.cfg_we === 1'b1) && !m_idle;
            if (m_idle) begin
                if (bus.start === 1'b1) begin
                    m_last = int'(bus.last_ctx);
                    if (m_last > 15) m_last = 15;
                    m_n = (bus.iter_count == 16'd0) ? 1 : int'(bus.iter_count);
                    for (int it = 0; it < m_n; it++)
                        for (int c = 0; c <= m_last; c++) m_seq.push_back(c);
                    m_cur  = m_seq.pop_front();
                    m_word = m_mem[m_cur];
                    m_run  = 1;
                end
                if (bus.cfg_we === 1'b1) m_mem[bus.cfg_addr] = bus.cfg_data;
            end else if (m_run) begin
                if (bus.abort === 1'b1) begin
                    m_run = 0; m_seq.delete();
                end else if (m_seq.size() > 0) begin
                    m_cur  = m_seq.pop_front();
                    m_word = m_mem[m_cur];
                end else begin
                    m_run = 0; m_done = 1;
                end
            end else begin
                m_done = 0;
            end
        end
    end

    logic [70:0] act_vec, exp_vec;
    always @(negedge CLK) begin
        if (chk_en) begin
            act_vec = {bus.busy, bus.done, bus.cfg_err, bus.ctx_ptr,
                       bus.fu_op, bus.write_back, bus.control_pe2fu_2, bus.control_pe2fu_1,
                       bus.control_send, bus.control_put_out, bus.control_put_in,
                       bus.control_reg_2, bus.control_reg_1, bus.control_out, bus.control_in,
                       bus.rf_ld, bus.rf_ld_write};
            exp_vec = {m_run, m_done, m_err, (m_run ? 4'(m_cur) : 4'd0),
                       (m_run ? m_word[61:0] : 62'd0), !m_run, 1'b0};
            check("cycle_outputs", act_vec, exp_vec);
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [63:0] d);
        bus.cfg_we = 1; bus.cfg_addr = a; bus.cfg_data = d;
        tick();
        bus.cfg_we = 0;
    endtask

    task automatic run_wait(input logic [3:0] last, input logic [15:0] iter,
                            output int cyc, output logic dn);
        bus.start = 1; bus.last_ctx = last; bus.iter_count = iter;
        tick();
        bus.start = 0;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            tick();
        end
        check("run_bounded", (cyc < 200), 1);
        dn = bus.done;
        tick();
    endtask

    logic [63:0] w;
    int          cyc;
    logic        dn;
    bit          saw_done;

    initial begin
        RST = 1;
        bus.cfg_we = 0; bus.cfg_addr = '0; bus.cfg_data = '0;
        bus.start = 0; bus.abort = 0; bus.last_ctx = '0; bus.iter_count = '0;
        repeat (3) tick();
        RST = 0;
        chk_en = 1;
        check("reset_busy", bus.busy, 0);
        check("reset_rf_ld", {bus.rf_ld, bus.rf_ld_write}, 2'b10);
        check("reset_fields", {bus.control_in, bus.control_put_in, bus.fu_op, bus.ctx_ptr}, 0);
        repeat (10) tick();
        check("idle_hold_rf_ld", bus.rf_ld, 1);

        // Distinct words: put_in = index+1, reserved bits set (must be ignored).
        for (int i = 0; i < 16; i++) begin
            w = {2'b11, 62'(64'h1357_9BDF_2468_ACE1 * 64'(i + 1))};
            w[35:30] = 6'(i + 1);
            cfg_write(4'(i), w);
        end
        tick();

        // last_ctx=2, iter_count=2: ptr 0,1,2,0,1,2 then done.
        bus.start = 1; bus.last_ctx = 4'd2; bus.iter_count = 16'd2;
        tick();
        bus.start = 0;
        for (int k = 0; k < 6; k++) begin
            check("seq_ptr", bus.ctx_ptr, k % 3);
            check("seq_put_in", bus.control_put_in, (k % 3) + 1);
            check("seq_busy", bus.busy, 1);
            tick();
        end
        check("seq_done_c7", {bus.done, bus.busy, bus.rf_ld}, 3'b101);
        tick();
        check("seq_done_pulse_end", bus.done, 0);

        // iter_count=0 behaves as 1.
        run_wait(4'd0, 16'd0, cyc, dn);
        check("iter0_cycles", cyc, 1);
        check("iter0_done", dn, 1);

        // Abort in second RUN cycle; stray start during run is ignored.
        bus.start = 1; bus.last_ctx = 4'd3; bus.iter_count = 16'd1;
        tick();
        bus.start = 0;
        check("abort_c1_ptr", bus.ctx_ptr, 0);
        tick();
        check("abort_c2_ptr", bus.ctx_ptr, 1);
        bus.abort = 1; bus.start = 1;
        tick();
        bus.abort = 0; bus.start = 0;
        check("abort_hold", {bus.busy, bus.rf_ld, bus.control_put_in, bus.ctx_ptr}, {1'b0, 1'b1, 6'd0, 4'd0});
        saw_done = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.done === 1'b1) saw_done = 1;
            tick();
        end
        check("abort_no_done", saw_done, 0);
        run_wait(4'd1, 16'd1, cyc, dn);
        check("after_abort_cycles", cyc, 2);
        check("after_abort_done", dn, 1);

        // cfg_we while running: rejected with cfg_err.
        bus.start = 1; bus.last_ctx = 4'd2; bus.iter_count = 16'd1;
        tick();
        bus.start = 0;
        cfg_write(4'd1, 64'h0FFF_FFFF_FFFF_FFFF);
        check("cfg_err_pulse", bus.cfg_err, 1);
        tick();
        check("cfg_err_one_cycle", bus.cfg_err, 0);
        repeat (3) tick();
        bus.start = 1; bus.last_ctx = 4'd1; bus.iter_count = 16'd1;
        tick();
        bus.start = 0;
        tick();
        check("mem1_unchanged", bus.control_put_in, 2);
        repeat (3) tick();

        // cfg_we to addr 0 together with start: old word now, new word next run.
        w = 64'h0;
        w[35:30] = 6'h2A;
        bus.cfg_we = 1; bus.cfg_addr = 4'd0; bus.cfg_data = w;
        bus.start = 1; bus.last_ctx = 4'd0; bus.iter_count = 16'd1;
        tick();
        bus.cfg_we = 0; bus.start = 0;
        check("wr_start_old", bus.control_put_in, 1);
        repeat (2) tick();
        bus.start = 1;
        tick();
        bus.start = 0;
        check("wr_start_new", bus.control_put_in, 6'h2A);
        repeat (2) tick();

        // Boundary lengths.
        run_wait(4'd15, 16'd1, cyc, dn);
        check("last15_cycles", cyc, 16);
        run_wait(4'd1, 16'd3, cyc, dn);
        check("iter3_cycles", cyc, 6);

        // Asynchronous reset mid-run at ctx_ptr=1; memory survives.
        bus.start = 1; bus.last_ctx = 4'd2; bus.iter_count = 16'd1;
        tick();
        bus.start = 0;
        tick();
        check("rst_pre_ptr", bus.ctx_ptr, 1);
        #2 RST = 1;
        #1;
        check("rst_async", {bus.busy, bus.rf_ld, bus.control_put_in, bus.ctx_ptr, bus.fu_op},
              {1'b0, 1'b1, 6'd0, 4'd0, 5'd0});
        tick();
        tick();
        RST = 0;
        tick();
        bus.start = 1; bus.last_ctx = 4'd2; bus.iter_count = 16'd1;
        tick();
        bus.start = 0;
        check("rerun_ctx0", bus.control_put_in, 6'h2A);
        tick();
        check("rerun_ctx1", bus.control_put_in, 2);
        tick();
        check("rerun_ctx2", bus.control_put_in, 3);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
